sparse_dot_multi_ch: RTL

Next-generation sparse dot-product engine. Computes NUM_CH output channels back-to-back from one start pulse, walking a CSR-style compressed weight store. Each channel has a descriptor of {base address, nnz count}. Per channel, the block fetches (index, value) pairs and gathers activations through a fully pipelined, one-MAC-per-cycle datapath, then requantises and emits one result per channel over a valid/ready handshake. It sits between the compressed weight store / activation RAM and the layer output buffer.

---
 rtl/sparse_pkg.sv | 36 +++
 rtl/sparse_mac_pipe.sv | 65 ++++++
 rtl/sparse_dot_multi_ch.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sparse_pkg.sv
// Shared types, default widths and saturation helper for the sparse dot engine.
// Optional RELU output clamp is enabled with SPARSE_DOT_RELU_EN.
package sparse_pkg;

    localparam int NUM_CH_D      = 16;
    localparam int INDEX_WIDTH_D = 12;
    localparam int DATA_WIDTH_D  = 16;
    localparam int ACC_WIDTH_D   = 40;
    localparam int ADDR_WIDTH_D  = 16;
    localparam int NNZ_WIDTH_D   = 16;
    localparam int OUT_WIDTH_D   = 16;
    localparam int SHIFT_D       = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC,
        S_RUN,
        S_DRAIN,
        S_EMIT
    } state_e;

    // Clamp x into the signed range of a w-bit value.
    function automatic logic signed [63:0] sat(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = ~hi;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/sparse_mac_pipe.sv
// Valid-tracked gather/multiply/accumulate pipeline (S1..S3) with
// saturating accumulator; part of sparse_dot_multi_ch (SPARSE_DOT_RELU_EN).
module sparse_mac_pipe
    import sparse_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int ACC_WIDTH  = ACC_WIDTH_D
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         issue_i,
    input  logic signed [DATA_WIDTH-1:0] wval_i,
    input  logic signed [DATA_WIDTH-1:0] act_i,
    output logic                         s1_v_o,
    output logic                         pend_o,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    logic                           s1_v_q;
    logic                           s2_v_q;
    logic                           s3_v_q;
    logic signed [DATA_WIDTH-1:0]   wv_q;
    logic signed [ACC_WIDTH-1:0]    prod_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [ACC_WIDTH-1:0]    acc_d;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH:0]             sum;

    // One guard bit detects overflow; clamp instead of wrapping.
    always_comb begin
        prod  = wv_q * act_i;
        sum   = {prod_q[ACC_WIDTH-1], prod_q} + {acc_q[ACC_WIDTH-1], acc_q};
        acc_d = sum[ACC_WIDTH-1:0];
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
            acc_d = {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
            wv_q   <= '0;
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            s1_v_q <= issue_i;
            s2_v_q <= s1_v_q;
            s3_v_q <= s2_v_q;
            if (s1_v_q) wv_q <= wval_i;
            if (s2_v_q) prod_q <= ACC_WIDTH'(prod);
            if (clr_i)
                acc_q <= '0;
            else if (s3_v_q)
                acc_q <= acc_d;
        end
    end

    assign s1_v_o = s1_v_q;
    // S3 lands in the accumulator on the same edge the FSM leaves DRAIN.
    assign pend_o = s1_v_q | s2_v_q;
    assign acc_o  = acc_q;

endmodule

// File: rtl/sparse_dot_multi_ch.sv
// Multi-channel CSR sparse dot-product engine: FSM, addressing, requant, output.
// Define SPARSE_DOT_RELU_EN to clamp negative results to zero.
module sparse_dot_multi_ch
    import sparse_pkg::*;
#(
    parameter int  NUM_CH      = NUM_CH_D,
    parameter int  INDEX_WIDTH = INDEX_WIDTH_D,
    parameter int  DATA_WIDTH  = DATA_WIDTH_D,
    parameter int  ACC_WIDTH   = ACC_WIDTH_D,
    parameter int  ADDR_WIDTH  = ADDR_WIDTH_D,
    parameter int  NNZ_WIDTH   = NNZ_WIDTH_D,
    parameter int  OUT_WIDTH   = OUT_WIDTH_D,
    parameter int  SHIFT       = SHIFT_D,
    localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [CHW-1:0]         desc_addr,
    input  logic [ADDR_WIDTH-1:0]  desc_base,
    input  logic [NNZ_WIDTH-1:0]   desc_nnz,
    output logic [ADDR_WIDTH-1:0]  weight_addr,
    output logic                   weight_rd,
    input  logic [INDEX_WIDTH-1:0] weight_idx,
    input  logic [DATA_WIDTH-1:0]  weight_val,
    output logic [INDEX_WIDTH-1:0] act_addr,
    output logic                   act_rd,
    input  logic [DATA_WIDTH-1:0]  act_data,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [CHW-1:0]         out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    state_e                  state_q;
    logic                    phase_q;
    logic [CHW-1:0]          ch_q;
    logic [NNZ_WIDTH-1:0]    rem_q;
    logic                    busy_q;
    logic                    done_q;
    logic [CHW-1:0]          desc_addr_q;
    logic [ADDR_WIDTH-1:0]   weight_addr_q;
    logic                    weight_rd_q;
    logic                    out_valid_q;
    logic [CHW-1:0]          out_ch_q;

    logic                    s1_v;
    logic                    pend;
    logic                    clr;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [63:0]      acc64;
    logic [OUT_WIDTH-1:0]    res;

    assign clr = (state_q == S_DESC) && !phase_q;

    sparse_mac_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .issue_i (weight_rd_q),
        .wval_i  (weight_val),
        .act_i   (act_data),
        .s1_v_o  (s1_v),
        .pend_o  (pend),
        .acc_o   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            phase_q       <= 1'b0;
            ch_q          <= '0;
            rem_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            desc_addr_q   <= '0;
            weight_addr_q <= '0;
            weight_rd_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_ch_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start) begin
                    state_q     <= S_DESC;
                    phase_q     <= 1'b0;
                    ch_q        <= '0;
                    desc_addr_q <= '0;
                    busy_q      <= 1'b1;
                end
                // Phase 0 presents the address, phase 1 sees the read data.
                S_DESC: if (!phase_q) begin
                    phase_q <= 1'b1;
                end else begin
                    phase_q       <= 1'b0;
                    weight_addr_q <= desc_base;
                    rem_q         <= desc_nnz - 1'b1;
                    if (desc_nnz == '0) begin
                        state_q <= S_DRAIN;
                    end else begin
                        state_q     <= S_RUN;
                        weight_rd_q <= 1'b1;
                    end
                end
                S_RUN: if (rem_q == '0) begin
                    weight_rd_q <= 1'b0;
                    state_q     <= S_DRAIN;
                end else begin
                    weight_addr_q <= weight_addr_q + 1'b1;
                    rem_q         <= rem_q - 1'b1;
                end
                S_DRAIN: if (!pend) begin
                    state_q     <= S_EMIT;
                    out_valid_q <= 1'b1;
                    out_ch_q    <= ch_q;
                end
                S_EMIT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    if (ch_q == CHW'(NUM_CH - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ch_q        <= ch_q + 1'b1;
                        desc_addr_q <= ch_q + 1'b1;
                        state_q     <= S_DESC;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc64 = {{(64-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
        res   = OUT_WIDTH'(sat(acc64 >>> SHIFT, OUT_WIDTH));
`ifdef SPARSE_DOT_RELU_EN
        if (res[OUT_WIDTH-1]) res = '0;
`endif
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign desc_addr   = desc_addr_q;
    assign weight_addr = weight_addr_q;
    assign weight_rd   = weight_rd_q;
    assign act_rd      = s1_v;
    assign act_addr    = s1_v ? weight_idx : '0;
    assign out_valid   = out_valid_q;
    assign out_ch      = out_ch_q;
    assign out_data    = out_valid_q ? res : '0;

endmodule
